// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_mem_pkg
//  Description : Shared constants and types for the program/data memory
//                port arbiter: port identifiers, arbiter state encoding,
//                read-mask value and latency counter width.
//  Revision    : 1.0  initial release
// ============================================================================
package riscv_mem_pkg;

    // Port identifiers, also used as bit positions in grant vectors
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // A zero write mask marks a read transaction
    localparam logic [3:0] WMASK_READ = 4'b0000;

    // Latency counter width; holds LATENCY-1 for LATENCY up to 4
    localparam int ARB_CNT_W = 2;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    // True when a captured mask describes a read
    function automatic logic is_read(input logic [3:0] wmask);
        return (wmask == WMASK_READ);
    endfunction

endpackage : riscv_mem_pkg
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pick
//  Description : Combinational two-way picker for the memory port arbiter.
//                A lone request always wins; on a tie either D wins outright
//                (D_PRIO != 0) or the port not granted last time wins.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arb_pick
    import riscv_mem_pkg::*;
#(
    parameter int D_PRIO = 0
) (
    input  logic       i_req_i,
    input  logic       i_req_d,
    input  logic       i_last_grant,
    output logic [1:0] o_gnt_vec
);

    // One-hot grant selection; all zero when nobody is asking
    always_comb begin
        o_gnt_vec = 2'b00;
        if (i_req_i && i_req_d) begin
            if ((D_PRIO != 0) || (i_last_grant == PORT_I)) begin
                o_gnt_vec[PORT_D] = 1'b1;
            end else begin
                o_gnt_vec[PORT_I] = 1'b1;
            end
        end else if (i_req_d) begin
            o_gnt_vec[PORT_D] = 1'b1;
        end else if (i_req_i) begin
            o_gnt_vec[PORT_I] = 1'b1;
        end
    end

endmodule : mem_arb_pick
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-port memory between the instruction-fetch
//                port (I, read-only) and the load/store port (D). One
//                transaction in flight: IDLE grants and captures, ISSUE
//                drives the memory strobe for one cycle, WAIT counts down the
//                fixed read latency and returns a one-cycle response strobe
//                to the owner with the memory data passed straight through.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int LATENCY = 1,   // memory read latency, 1..4 cycles
    parameter int D_PRIO  = 0    // 0: round-robin on ties, 1: D wins ties
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_wmask,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    // Value loaded into the countdown in ISSUE; zero in WAIT marks data valid
    localparam logic [ARB_CNT_W-1:0] c_cnt_load = ARB_CNT_W'(LATENCY - 1);

    arb_state_e             state_q, state_d;
    logic                   owner_q, owner_d;   // doubles as last-grant record
    logic [31:0]            addr_q,  addr_d;
    logic [3:0]             wmask_q, wmask_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [ARB_CNT_W-1:0]   cnt_q,   cnt_d;

    logic [1:0]             w_pick;
    logic [1:0]             w_gnt;
    logic                   w_resp;

    mem_arb_pick #(
        .D_PRIO       (D_PRIO)
    ) u_pick (
        .i_req_i      (i_req),
        .i_req_d      (d_req),
        .i_last_grant (owner_q),
        .o_gnt_vec    (w_pick)
    );

    // Grants exist only while idle, so a held request waits out the response
    assign w_gnt  = (state_q == ST_IDLE) ? w_pick : 2'b00;
    assign i_gnt  = w_gnt[PORT_I];
    assign d_gnt  = w_gnt[PORT_D];

    // The response cycle is the WAIT cycle whose countdown has reached zero
    assign w_resp = (state_q == ST_WAIT) && (cnt_q == '0);

    // State register, capture registers and latency counter
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            owner_q <= PORT_I;
            addr_q  <= '0;
            wmask_q <= WMASK_READ;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wmask_q <= wmask_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: capture on grant, load the countdown, count to zero
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wmask_d = wmask_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_gnt[PORT_D]) begin
                    state_d = ST_ISSUE;
                    owner_d = PORT_D;
                    addr_d  = d_addr;
                    wmask_d = d_wmask;
                    wdata_d = d_wdata;
                end else if (w_gnt[PORT_I]) begin
                    // The fetch port never writes
                    state_d = ST_ISSUE;
                    owner_d = PORT_I;
                    addr_d  = i_addr;
                    wmask_d = WMASK_READ;
                    wdata_d = '0;
                end
            end
            ST_ISSUE: begin
                cnt_d   = c_cnt_load;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - ARB_CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Memory side and response outputs, decoded from registered state only
    always_comb begin
        mem_addr  = '0;
        mem_read  = 1'b0;
        mem_wmask = WMASK_READ;
        mem_wdata = '0;
        i_rvalid  = 1'b0;
        i_rdata   = '0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        case (state_q)
            ST_ISSUE: begin
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (is_read(wmask_q)) begin
                    mem_read = 1'b1;
                end else begin
                    mem_wmask = wmask_q;
                end
            end
            ST_WAIT: begin
                mem_addr = addr_q;
                if (w_resp) begin
                    if (owner_q == PORT_D) begin
                        d_rvalid = 1'b1;
                        d_rdata  = mem_rdata;
                    end else begin
                        i_rvalid = 1'b1;
                        i_rdata  = mem_rdata;
                    end
                end
            end
            default: begin
                mem_addr = '0;
            end
        endcase
    end

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter. Three instances
//                (LATENCY/D_PRIO = 1/0, 3/0, 1/1) each with a small latency
//                memory model; directed table, multi-cycle sequences and a
//                random phase checked against a transaction-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int N_DUT = 3;
    localparam int NV    = 22;
    localparam int N_RND = 1500;

    function automatic int lat_of(input int k);
        return (k == 1) ? 3 : 1;
    endfunction

    function automatic int prio_of(input int k);
        return (k == 2) ? 1 : 0;
    endfunction

    // Power-up memory image; word 2 holds a NOP
    function automatic logic [31:0] init_word(input int w);
        if (w == 2) return 32'h0000_0013;
        return (32'(w) * 32'h0101_0101) ^ 32'hA500_0000;
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        i_req     [N_DUT];
    logic [31:0] i_addr    [N_DUT];
    logic        i_gnt     [N_DUT];
    logic        i_rvalid  [N_DUT];
    logic [31:0] i_rdata   [N_DUT];
    logic        d_req     [N_DUT];
    logic [31:0] d_addr    [N_DUT];
    logic [3:0]  d_wmask   [N_DUT];
    logic [31:0] d_wdata   [N_DUT];
    logic        d_gnt     [N_DUT];
    logic        d_rvalid  [N_DUT];
    logic [31:0] d_rdata   [N_DUT];
    logic [31:0] mem_addr  [N_DUT];
    logic        mem_read  [N_DUT];
    logic [3:0]  mem_wmask [N_DUT];
    logic [31:0] mem_wdata [N_DUT];

    for (genvar k = 0; k < N_DUT; k++) begin : g_dut
        localparam int LAT = lat_of(k);
        logic [31:0] mem  [256];
        logic [31:0] pipe [4];

        mem_port_arbiter #(
            .LATENCY   (LAT),
            .D_PRIO    (prio_of(k))
        ) u_dut (
            .CLK       (clk),
            .RESET     (rst),
            .i_req     (i_req[k]),
            .i_addr    (i_addr[k]),
            .i_gnt     (i_gnt[k]),
            .i_rvalid  (i_rvalid[k]),
            .i_rdata   (i_rdata[k]),
            .d_req     (d_req[k]),
            .d_addr    (d_addr[k]),
            .d_wmask   (d_wmask[k]),
            .d_wdata   (d_wdata[k]),
            .d_gnt     (d_gnt[k]),
            .d_rvalid  (d_rvalid[k]),
            .d_rdata   (d_rdata[k]),
            .mem_addr  (mem_addr[k]),
            .mem_read  (mem_read[k]),
            .mem_wmask (mem_wmask[k]),
            .mem_wdata (mem_wdata[k]),
            .mem_rdata (pipe[LAT-1])
        );

        initial begin
            for (int w = 0; w < 256; w++) mem[w] = init_word(w);
        end

        // Memory with a LAT-deep read pipeline and byte-lane writes
        always @(posedge clk) begin
            for (int j = 3; j > 0; j--) pipe[j] <= pipe[j-1];
            pipe[0] <= mem_read[k] ? mem[mem_addr[k][9:2]] : 32'h0;
            for (int b = 0; b < 4; b++) begin
                if (mem_wmask[k][b]) mem[mem_addr[k][9:2]][8*b +: 8] <= mem_wdata[k][8*b +: 8];
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [8:0] ctl(input int k);
        return {i_gnt[k], d_gnt[k], i_rvalid[k], d_rvalid[k], mem_read[k], mem_wmask[k]};
    endfunction

    task automatic clear_inputs();
        for (int k = 0; k < N_DUT; k++) begin
            i_req[k] = 1'b0; i_addr[k] = '0;
            d_req[k] = 1'b0; d_addr[k] = '0; d_wmask[k] = '0; d_wdata[k] = '0;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct packed {
        logic        ireq;
        logic [31:0] ia;
        logic        dreq;
        logic [31:0] da;
        logic [3:0]  dm;
        logic [31:0] dw;
        logic [8:0]  c;     // {i_gnt, d_gnt, i_rvalid, d_rvalid, mem_read, mem_wmask}
        logic [31:0] ma;
        logic [31:0] ird;
        logic [31:0] drd;
        logic        ckd;   // compare d_rdata this cycle
    } vec_t;

    function automatic vec_t mk(input logic ireq, input logic [31:0] ia, input logic dreq,
                                input logic [31:0] da, input logic [3:0] dm, input logic [31:0] dw,
                                input logic [8:0] c, input logic [31:0] ma, input logic [31:0] ird,
                                input logic [31:0] drd, input logic ckd);
        vec_t v;
        v.ireq = ireq; v.ia = ia; v.dreq = dreq; v.da = da; v.dm = dm; v.dw = dw;
        v.c = c; v.ma = ma; v.ird = ird; v.drd = drd; v.ckd = ckd;
        return v;
    endfunction

    // Transaction-level reference state for the random phase
    int          busy     [N_DUT];
    logic        last_d   [N_DUT];
    int          rsp_at   [N_DUT];
    logic        rsp_d    [N_DUT];
    logic        rsp_wr   [N_DUT];
    logic [31:0] rsp_data [N_DUT];
    logic        gi_seen  [N_DUT];
    logic        gd_seen  [N_DUT];
    logic [31:0] rmem     [N_DUT][64];

    initial begin
        vec_t        tv [NV];
        logic [31:0] w4;
        logic [31:0] w100;
        w4   = init_word(4);
        w100 = (init_word(100) & 32'hFFFF_00FF) | 32'h0000_AB00;

        //        ireq ia     dreq da      dm       dw        ctl                ma       ird    drd  ckd
        tv[0]  = mk(1, 'h8,   0, 'h0,   4'h0,   'h0,    9'b1_0_0_0_0_0000, 'h0,    'h0,  'h0, 1);
        tv[1]  = mk(0, 'h0,   0, 'h0,   4'h0,   'h0,    9'b0_0_0_0_1_0000, 'h8,    'h0,  'h0, 1);
        tv[2]  = mk(0, 'h0,   0, 'h0,   4'h0,   'h0,    9'b0_0_1_0_0_0000, 'h8,    'h13, 'h0, 1);
        tv[3]  = mk(1, 'h8,   1, 'h10,  4'h0,   'h0,    9'b0_1_0_0_0_0000, 'h0,    'h0,  'h0, 1);
        tv[4]  = mk(1, 'h8,   1, 'h10,  4'h0,   'h0,    9'b0_0_0_0_1_0000, 'h10,   'h0,  'h0, 1);
        tv[5]  = mk(1, 'h8,   1, 'h10,  4'h0,   'h0,    9'b0_0_0_1_0_0000, 'h10,   'h0,  w4,  1);
        tv[6]  = mk(1, 'h8,   1, 'h10,  4'h0,   'h0,    9'b1_0_0_0_0_0000, 'h0,    'h0,  'h0, 1);
        tv[7]  = mk(1, 'h8,   1, 'h10,  4'h0,   'h0,    9'b0_0_0_0_1_0000, 'h8,    'h0,  'h0, 1);
        tv[8]  = mk(1, 'h8,   1, 'h10,  4'h0,   'h0,    9'b0_0_1_0_0_0000, 'h8,    'h13, 'h0, 1);
        tv[9]  = mk(1, 'h8,   1, 'h10,  4'h0,   'h0,    9'b0_1_0_0_0_0000, 'h0,    'h0,  'h0, 1);
        tv[10] = mk(1, 'h8,   0, 'h0,   4'h0,   'h0,    9'b0_0_0_0_1_0000, 'h10,   'h0,  'h0, 1);
        tv[11] = mk(1, 'h8,   0, 'h0,   4'h0,   'h0,    9'b0_0_0_1_0_0000, 'h10,   'h0,  w4,  1);
        tv[12] = mk(1, 'h8,   0, 'h0,   4'h0,   'h0,    9'b1_0_0_0_0_0000, 'h0,    'h0,  'h0, 1);
        tv[13] = mk(0, 'h0,   0, 'h0,   4'h0,   'h0,    9'b0_0_0_0_1_0000, 'h8,    'h0,  'h0, 1);
        tv[14] = mk(0, 'h0,   0, 'h0,   4'h0,   'h0,    9'b0_0_1_0_0_0000, 'h8,    'h13, 'h0, 1);
        tv[15] = mk(0, 'h0,   1, 'h190, 4'b0010, 'hAB00, 9'b0_1_0_0_0_0000, 'h0,    'h0,  'h0, 1);
        tv[16] = mk(0, 'h0,   0, 'h0,   4'h0,   'h0,    9'b0_0_0_0_0_0010, 'h190,  'h0,  'h0, 1);
        tv[17] = mk(0, 'h0,   0, 'h0,   4'h0,   'h0,    9'b0_0_0_1_0_0000, 'h190,  'h0,  'h0, 0);
        tv[18] = mk(0, 'h0,   1, 'h190, 4'h0,   'h0,    9'b0_1_0_0_0_0000, 'h0,    'h0,  'h0, 1);
        tv[19] = mk(0, 'h0,   0, 'h0,   4'h0,   'h0,    9'b0_0_0_0_1_0000, 'h190,  'h0,  'h0, 1);
        tv[20] = mk(0, 'h0,   0, 'h0,   4'h0,   'h0,    9'b0_0_0_1_0_0000, 'h190,  'h0,  w100, 1);
        tv[21] = mk(0, 'h0,   0, 'h0,   4'h0,   'h0,    9'b0_0_0_0_0_0000, 'h0,    'h0,  'h0, 1);

        // Reset state
        clear_inputs();
        rst = 1'b1;
        #2;
        for (int k = 0; k < N_DUT; k++) begin
            chk($sformatf("reset ctl dut%0d", k), ctl(k), 9'h0);
            chk($sformatf("reset mem_addr dut%0d", k), mem_addr[k], 32'h0);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Directed table on the LATENCY=1 round-robin instance
        for (int n = 0; n < NV; n++) begin
            i_req[0] = tv[n].ireq; i_addr[0] = tv[n].ia;
            d_req[0] = tv[n].dreq; d_addr[0] = tv[n].da;
            d_wmask[0] = tv[n].dm; d_wdata[0] = tv[n].dw;
            @(negedge clk);
            chk($sformatf("vec%0d ctl", n), ctl(0), tv[n].c);
            chk($sformatf("vec%0d mem_addr", n), mem_addr[0], tv[n].ma);
            chk($sformatf("vec%0d i_rdata", n), i_rdata[0], tv[n].ird);
            if (tv[n].ckd) chk($sformatf("vec%0d d_rdata", n), d_rdata[0], tv[n].drd);
            next_cycle();
        end
        clear_inputs();

        // LATENCY=3: response four cycles after the grant cycle; D waits for IDLE
        i_req[1] = 1'b1; i_addr[1] = 32'h8;
        @(negedge clk);
        chk("lat3 i_gnt", i_gnt[1], 1'b1);
        next_cycle();
        i_req[1] = 1'b0;
        @(negedge clk);
        chk("lat3 mem_read", mem_read[1], 1'b1);
        next_cycle();
        d_req[1] = 1'b1; d_addr[1] = 32'h10; d_wmask[1] = 4'h0;
        for (int s = 2; s <= 5; s++) begin
            @(negedge clk);
            chk($sformatf("lat3 i_rvalid s%0d", s), i_rvalid[1], (s == 4));
            chk($sformatf("lat3 d_gnt s%0d", s), d_gnt[1], (s == 5));
            if (s == 4) chk("lat3 i_rdata", i_rdata[1], 32'h13);
            next_cycle();
        end
        d_req[1] = 1'b0;
        for (int s = 6; s <= 9; s++) begin
            @(negedge clk);
            chk($sformatf("lat3 d_rvalid s%0d", s), d_rvalid[1], (s == 9));
            if (s == 9) chk("lat3 d_rdata", d_rdata[1], init_word(4));
            next_cycle();
        end

        // Fixed D priority: D takes every idle slot while it keeps asking
        i_req[2] = 1'b1; i_addr[2] = 32'h8;
        d_req[2] = 1'b1; d_addr[2] = 32'h10; d_wmask[2] = 4'h0;
        for (int t = 0; t < 9; t++) begin
            @(negedge clk);
            chk($sformatf("dprio gnt t%0d", t), {i_gnt[2], d_gnt[2]}, (t % 3 == 0) ? 2'b01 : 2'b00);
            next_cycle();
        end
        d_req[2] = 1'b0;
        @(negedge clk);
        chk("dprio i_gnt after d drops", {i_gnt[2], d_gnt[2]}, 2'b10);
        next_cycle();
        i_req[2] = 1'b0;
        repeat (2) next_cycle();

        // Reset during WAIT (dut1) and ISSUE (dut0)
        i_req[1] = 1'b1; i_addr[1] = 32'h8;
        @(negedge clk);
        chk("rstmid dut1 i_gnt", i_gnt[1], 1'b1);
        next_cycle();
        i_req[1] = 1'b0;
        d_req[0] = 1'b1; d_addr[0] = 32'h10; d_wmask[0] = 4'h0;
        @(negedge clk);
        chk("rstmid dut0 d_gnt", d_gnt[0], 1'b1);
        next_cycle();
        d_req[0] = 1'b0;
        @(negedge clk);
        chk("rstmid dut0 mem_read", mem_read[0], 1'b1);
        chk("rstmid dut1 mem_addr", mem_addr[1], 32'h8);
        #1 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rstmid ctl dut%0d", k), ctl(k), 9'h0);
            chk($sformatf("rstmid mem_addr dut%0d", k), mem_addr[k], 32'h0);
            chk($sformatf("rstmid rdata dut%0d", k), {i_rdata[k], d_rdata[k]}, 64'h0);
        end
        next_cycle();
        rst = 1'b0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            chk($sformatf("rstmid no resp dut0 t%0d", t), ctl(0), 9'h0);
            chk($sformatf("rstmid no resp dut1 t%0d", t), ctl(1), 9'h0);
            next_cycle();
        end
        for (int k = 0; k < 2; k++) begin
            i_req[k] = 1'b1; i_addr[k] = 32'h8;
            d_req[k] = 1'b1; d_addr[k] = 32'h10; d_wmask[k] = 4'h0;
        end
        @(negedge clk);
        chk("rstmid tie dut0", {i_gnt[0], d_gnt[0]}, 2'b01);
        chk("rstmid tie dut1", {i_gnt[1], d_gnt[1]}, 2'b01);
        next_cycle();

        // Random traffic against the transaction-level model
        do_reset();
        for (int k = 0; k < N_DUT; k++) begin
            busy[k] = 0; last_d[k] = 1'b0; rsp_at[k] = -1;
            rsp_d[k] = 1'b0; rsp_wr[k] = 1'b0; rsp_data[k] = '0;
            gi_seen[k] = 1'b0; gd_seen[k] = 1'b0;
            for (int w = 0; w < 64; w++) rmem[k][w] = init_word(w);
        end
        for (int c = 0; c < N_RND; c++) begin
            for (int k = 0; k < N_DUT; k++) begin
                if (gi_seen[k]) i_req[k] = 1'b0;
                if (gd_seen[k]) d_req[k] = 1'b0;
                if (!i_req[k] && ($urandom_range(0, 2) == 0)) begin
                    i_req[k]  = 1'b1;
                    i_addr[k] = 32'($urandom_range(0, 63)) << 2;
                end
                if (!d_req[k] && ($urandom_range(0, 2) == 0)) begin
                    d_req[k]   = 1'b1;
                    d_addr[k]  = 32'($urandom_range(0, 63)) << 2;
                    d_wmask[k] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
                    d_wdata[k] = $urandom;
                end
            end
            @(negedge clk);
            for (int k = 0; k < N_DUT; k++) begin
                logic eig, edg, eirv, edrv;
                int   widx;
                eig = 1'b0; edg = 1'b0;
                if (busy[k] == 0) begin
                    if (i_req[k] && d_req[k]) begin
                        if ((prio_of(k) != 0) || !last_d[k]) edg = 1'b1; else eig = 1'b1;
                    end else if (d_req[k]) begin
                        edg = 1'b1;
                    end else if (i_req[k]) begin
                        eig = 1'b1;
                    end
                    if (eig || edg) begin
                        busy[k]   = lat_of(k) + 2;
                        rsp_at[k] = c + lat_of(k) + 1;
                        rsp_d[k]  = edg;
                        last_d[k] = edg;
                        widx = edg ? int'(d_addr[k][7:2]) : int'(i_addr[k][7:2]);
                        if (edg && (d_wmask[k] != 4'h0)) begin
                            rsp_wr[k] = 1'b1;
                            for (int b = 0; b < 4; b++)
                                if (d_wmask[k][b]) rmem[k][widx][8*b +: 8] = d_wdata[k][8*b +: 8];
                        end else begin
                            rsp_wr[k]   = 1'b0;
                            rsp_data[k] = rmem[k][widx];
                        end
                    end
                end
                eirv = (rsp_at[k] == c) && !rsp_d[k];
                edrv = (rsp_at[k] == c) && rsp_d[k];
                chk($sformatf("rnd dut%0d c%0d gnt", k, c), {i_gnt[k], d_gnt[k]}, {eig, edg});
                chk($sformatf("rnd dut%0d c%0d rvalid", k, c), {i_rvalid[k], d_rvalid[k]}, {eirv, edrv});
                chk($sformatf("rnd dut%0d c%0d i_rdata", k, c), i_rdata[k], eirv ? rsp_data[k] : 32'h0);
                if (!(edrv && rsp_wr[k]))
                    chk($sformatf("rnd dut%0d c%0d d_rdata", k, c), d_rdata[k], edrv ? rsp_data[k] : 32'h0);
                gi_seen[k] = i_gnt[k];
                gd_seen[k] = d_gnt[k];
                if (busy[k] > 0) busy[k]--;
            end
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
